// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frames payload bits into an external convolutional
// encoder, appends zero tail bits, tracks every encoder cycle through a
// fixed-latency delay line and compares decoded payload bits against what
// was sent, counting bit errors and completed frames.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int TAIL_LEN  = 2,
  parameter int DEC_LAT   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        bit_valid_i,
  input  logic        bit_i,
  output logic        bit_ready_o,
  output logic        enc_en_o,
  output logic        enc_bit_o,
  input  logic        dec_bit_i,
  output logic        dec_valid_o,
  output logic        dec_bit_o,
  output logic [15:0] err_cnt_o,
  output logic [15:0] frame_cnt_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LEN_C  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(FRAME_LEN - 1);
  localparam logic [3:0]    TLAST_C = (TAIL_LEN == 0) ? 4'd0 : 4'(TAIL_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TAIL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_in_cnt;
  logic [CW-1:0]       r_cap_cnt;
  logic [3:0]          r_tail_cnt;
  logic                r_enc_en;
  logic                r_enc_bit;
  logic                r_enc_pay;
  logic                r_dec_valid;
  logic                r_dec_bit;
  logic [15:0]         r_err;
  logic [15:0]         r_frame_cnt;
  logic                r_done;
  logic [DEC_LAT-1:0]  r_dl_en;
  logic [DEC_LAT-1:0]  r_dl_pay;
  logic [DEC_LAT-1:0]  r_dl_bit;

  logic w_ready;
  logic w_xfer;
  logic w_last_xfer;
  logic w_cap;
  logic w_mismatch;
  logic w_cap_done;

  // Handshake, delay-line tap and frame-completion decode
  always_comb begin
    w_ready     = (r_state == S_LOAD) && (r_in_cnt < LEN_C);
    w_xfer      = bit_valid_i & w_ready;
    w_last_xfer = w_xfer && (r_in_cnt == LAST_C);
    w_cap       = r_dl_en[DEC_LAT-1] & r_dl_pay[DEC_LAT-1];
    w_mismatch  = w_cap && (dec_bit_i != r_dl_bit[DEC_LAT-1]);
    // Captures run in every state, so the last payload bit may already have
    // been captured before DRAIN is reached (short latency, long tail).
    w_cap_done  = (r_cap_cnt == LEN_C) || (w_cap && (r_cap_cnt == LAST_C));
  end

  assign bit_ready_o = w_ready;
  assign enc_en_o    = r_enc_en;
  assign enc_bit_o   = r_enc_bit;
  assign dec_valid_o = r_dec_valid;
  assign dec_bit_o   = r_dec_bit;
  assign err_cnt_o   = r_err;
  assign frame_cnt_o = r_frame_cnt;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;

  // Delay line mirroring the decoder latency for each encoder cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dl_en  <= '0;
      r_dl_pay <= '0;
      r_dl_bit <= '0;
    end else begin
      r_dl_en[0]  <= r_enc_en;
      r_dl_pay[0] <= r_enc_pay;
      r_dl_bit[0] <= r_enc_bit;
      for (int unsigned i = 1; i < DEC_LAT; i++) begin
        r_dl_en[i]  <= r_dl_en[i-1];
        r_dl_pay[i] <= r_dl_pay[i-1];
        r_dl_bit[i] <= r_dl_bit[i-1];
      end
    end
  end

  // Frame FSM with registered encoder, capture and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_cnt    <= '0;
      r_cap_cnt   <= '0;
      r_tail_cnt  <= '0;
      r_enc_en    <= 1'b0;
      r_enc_bit   <= 1'b0;
      r_enc_pay   <= 1'b0;
      r_dec_valid <= 1'b0;
      r_dec_bit   <= 1'b0;
      r_err       <= '0;
      r_frame_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_enc_en    <= 1'b0;
      r_enc_bit   <= 1'b0;
      r_enc_pay   <= 1'b0;
      r_dec_valid <= 1'b0;
      r_done      <= 1'b0;

      if (w_cap) begin
        r_dec_valid <= 1'b1;
        r_dec_bit   <= dec_bit_i;
        r_cap_cnt   <= r_cap_cnt + 1'b1;
        if (w_mismatch && (r_err != '1)) r_err <= r_err + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state    <= S_LOAD;
            r_in_cnt   <= '0;
            r_cap_cnt  <= '0;
            r_tail_cnt <= '0;
            r_err      <= '0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_enc_en  <= 1'b1;
            r_enc_bit <= bit_i;
            r_enc_pay <= 1'b1;
            r_in_cnt  <= r_in_cnt + 1'b1;
            if (w_last_xfer) r_state <= (TAIL_LEN == 0) ? S_DRAIN : S_TAIL;
          end
        end
        S_TAIL: begin
          r_enc_en   <= 1'b1;
          r_tail_cnt <= r_tail_cnt + 4'd1;
          if (r_tail_cnt == TLAST_C) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_cap_done) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 64, payload bits per frame (range 1..1024).
REQ-002 Parameter TAIL_LEN, default 2, zero flush bits appended per frame (K-1 for K=3), range 0..8.
REQ-003 Parameter DEC_LAT, default 32, fixed decoder latency in clk cycles from enc_en_o to matching dec_bit_i (range 1..64).
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  single-cycle frame start request.
REQ-007 bit_valid_i  input  1  payload bit offered.
REQ-008 bit_i  input  1  payload bit value.
REQ-009 bit_ready_o  output  1  controller accepts payload bit this cycle.
REQ-010 enc_en_o  output  1  encoder enable, registered.
REQ-011 enc_bit_o  output  1  encoder data bit, registered.
REQ-012 dec_bit_i  input  1  decoder output bit.
REQ-013 dec_valid_o  output  1  registered strobe: decoded payload bit captured.
REQ-014 dec_bit_o  output  1  registered copy of captured decoded payload bit.
REQ-015 err_cnt_o  output  16  decoded-vs-sent payload bit mismatches in current frame.
REQ-016 frame_cnt_o  output  16  completed frames since reset.
REQ-017 busy_o  output  1  high in any state other than IDLE.
REQ-018 done_o  output  1  one-cycle pulse on frame completion.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, TAIL, DRAIN, DONE.
REQ-020 IDLE -> LOAD on start_i=1; start_i in any other state SHALL be ignored, including DONE.
REQ-021 On start acceptance, err_cnt_o SHALL clear to 0 and payload/capture counters SHALL clear to 0.
REQ-022 bit_ready_o SHALL be high only in LOAD with fewer than FRAME_LEN bits accepted (combinational from state/counter).
REQ-023 Transfer occurs when bit_valid_i & bit_ready_o; next cycle enc_en_o=1, enc_bit_o=bit_i.
REQ-024 Cycle in LOAD without transfer: next cycle enc_en_o=0, enc_bit_o=0 (gaps permitted).
REQ-025 LOAD -> TAIL on the cycle of the FRAME_LEN-th transfer; if TAIL_LEN=0, LOAD -> DRAIN directly.
REQ-026 TAIL SHALL emit exactly TAIL_LEN consecutive cycles of enc_en_o=1, enc_bit_o=0, then go to DRAIN.
REQ-027 Controller SHALL track each enc_en_o cycle through a DEC_LAT-deep delay line carrying enable, payload flag and sent bit.
REQ-028 When delay-line tap shows an enabled payload entry, dec_bit_i SHALL be sampled that cycle; next cycle dec_valid_o=1, dec_bit_o=sampled value.
REQ-029 Tail entries SHALL NOT produce dec_valid_o and SHALL NOT be compared.
REQ-030 Each captured payload bit differing from its sent bit SHALL increment err_cnt_o by 1, saturating at 16'hFFFF.
REQ-031 DRAIN -> DONE in the cycle the FRAME_LEN-th payload bit is captured; DONE lasts one cycle with done_o=1, then -> IDLE.
REQ-032 frame_cnt_o SHALL increment by 1 on entry to DONE, wrapping 16'hFFFF -> 0.
REQ-033 err_cnt_o SHALL hold its final value in IDLE until next accepted start.
REQ-034 Captures from the delay line SHALL continue in any state, so payload bits in flight at LOAD->TAIL or TAIL->DRAIN are never lost.
REQ-035 bit_valid_i outside LOAD, or after FRAME_LEN transfers, SHALL be ignored.

Reset
REQ-036 On rst=0, asynchronously: state IDLE; enc_en_o, enc_bit_o, dec_valid_o, dec_bit_o, done_o = 0; err_cnt_o, frame_cnt_o = 0; delay line cleared.
REQ-037 Reset mid-frame SHALL abort the frame with no done_o pulse; frame_cnt_o SHALL read 0 after release.
REQ-038 First start_i SHALL be honoured on the first rising edge after rst deasserts.

Verification (FRAME_LEN=8, TAIL_LEN=2, DEC_LAT=4, decoder model = 4-cycle delay of enc_bit_o)
REQ-039 start, 8 contiguous bits 10110010 -> enc_en_o high 10 cycles (payload then 00); dec_bit_o sequence 10110010; err_cnt_o=0; single done_o; frame_cnt_o=1.
REQ-040 Same frame, model inverts decoded bits 3 and 5 -> err_cnt_o=2 at done_o; dec_valid_o asserted exactly 8 times.
REQ-041 bit_valid_i low 3 cycles after bit 4 -> enc_en_o gap of 3 cycles; decoded bits still aligned; err_cnt_o=0.
REQ-042 start_i pulsed during LOAD and during DONE -> ignored; exactly one frame; frame_cnt_o=1.
REQ-043 rst asserted during TAIL -> all outputs 0 immediately; no done_o; a new start after release runs a full clean frame.
REQ-044 Preload frame_cnt_o to 16'hFFFF via 65535 frames (or force) and run one more -> frame_cnt_o=0.
